kara_mult_iter: RTL and testbench

- Parametrised one-level Karatsuba multiplier for the modular-multiplier datapath. The three sub-products (lo, hi, mid) are time-multiplexed through one shared, pipelined half-width multiplier instead of three parallel instances.
- Trades throughput for area. Adds valid/ready handshakes, a tag passthrough and back-pressure.
- Sits between the operand scheduler and the Montgomery reduction stage.

---
 rtl/kara_mult_iter.sv | 200 ++++++++++++++++++++
 tb/tb_kara_mult_iter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kara_mult_iter.sv
// One-level Karatsuba multiplier with a single shared pipelined half-width
// multiplier, time-multiplexed over the lo, hi and mid sub-products.
module kara_mult_iter #(
    parameter int WIDTH      = 130,
    parameter int MUL_STAGES = 2,
    parameter int TAG_W      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic [TAG_W-1:0]   out_tag
);
    localparam int H   = (WIDTH + 1) / 2;
    localparam int M   = H + 1;
    localparam int PW  = 2 * M;
    localparam int P1W = 2 * H + 3;
    localparam int OW  = 2 * WIDTH;
    localparam int L   = MUL_STAGES - 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        COMBINE,
        HOLD
    } state_t;

    state_t state, state_n;
    logic [1:0] cnt, cnt_n;
    logic accept;
    logic issue;

    logic [WIDTH-1:0] a_q, b_q;
    logic [TAG_W-1:0] tag_q;

    logic [H-1:0] a0, a1, b0, b1;
    logic [M-1:0] s_a, s_b;
    logic [M-1:0] op_x, op_y;
    logic [PW-1:0] prod;

    logic [PW-1:0] pipe_p [MUL_STAGES];
    logic          pipe_v [MUL_STAGES];
    logic [1:0]    pipe_s [MUL_STAGES];

    logic [PW-1:0]  p0_q, p2_q, pm_q;
    logic           pm_done;
    logic [P1W-1:0] p1;
    logic [OW-1:0]  comb_p;

    assign in_ready  = (state == IDLE) || (state == HOLD && out_ready);
    assign accept    = in_valid && in_ready;
    assign issue     = (state == ISSUE);
    assign out_valid = (state == HOLD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n = ISSUE;
                    cnt_n   = 2'd0;
                end
            end
            ISSUE: begin
                if (cnt == 2'd2) begin
                    state_n = DRAIN;
                    cnt_n   = 2'd0;
                end else begin
                    cnt_n = cnt + 2'd1;
                end
            end
            DRAIN: begin
                if (pm_done) state_n = COMBINE;
            end
            COMBINE: state_n = HOLD;
            HOLD: begin
                if (out_ready) begin
                    state_n = in_valid ? ISSUE : IDLE;
                    cnt_n   = 2'd0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            tag_q <= '0;
        end else if (accept) begin
            a_q   <= in_a;
            b_q   <= in_b;
            tag_q <= in_tag;
        end
    end

    // Upper halves are zero-extended so odd widths share the same H split
    assign a0  = a_q[H-1:0];
    assign a1  = H'(a_q[WIDTH-1:H]);
    assign b0  = b_q[H-1:0];
    assign b1  = H'(b_q[WIDTH-1:H]);
    assign s_a = M'(a0) + M'(a1);
    assign s_b = M'(b0) + M'(b1);

    always_comb begin
        op_x = M'(a0);
        op_y = M'(b0);
        case (cnt)
            2'd1: begin
                op_x = M'(a1);
                op_y = M'(b1);
            end
            2'd2: begin
                op_x = s_a;
                op_y = s_b;
            end
            default: ;
        endcase
    end

    assign prod = PW'(op_x) * PW'(op_y);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MUL_STAGES; i++) begin
                pipe_p[i] <= '0;
                pipe_v[i] <= 1'b0;
                pipe_s[i] <= 2'd0;
            end
        end else begin
            pipe_p[0] <= prod;
            pipe_v[0] <= issue;
            pipe_s[0] <= cnt;
            for (int i = 1; i < MUL_STAGES; i++) begin
                pipe_p[i] <= pipe_p[i-1];
                pipe_v[i] <= pipe_v[i-1];
                pipe_s[i] <= pipe_s[i-1];
            end
        end
    end

    // The mid product is issued last, so its arrival marks all three done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0_q    <= '0;
            p2_q    <= '0;
            pm_q    <= '0;
            pm_done <= 1'b0;
        end else begin
            if (accept) begin
                pm_done <= 1'b0;
            end else if (pipe_v[L] && pipe_s[L] == 2'd2) begin
                pm_done <= 1'b1;
            end
            if (pipe_v[L]) begin
                case (pipe_s[L])
                    2'd0:    p0_q <= pipe_p[L];
                    2'd1:    p2_q <= pipe_p[L];
                    default: pm_q <= pipe_p[L];
                endcase
            end
        end
    end

    assign p1 = P1W'(pm_q) - P1W'(p0_q) - P1W'(p2_q);

    assign comb_p = OW'(p0_q)
                  + (OW'(p1) << H)
                  + (OW'(p2_q) << (2 * H));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_p   <= '0;
            out_tag <= '0;
        end else if (state == COMBINE) begin
            out_p   <= comb_p;
            out_tag <= tag_q;
        end
    end

endmodule

// File: tb/tb_kara_mult_iter.sv
// Directed bench for kara_mult_iter: 8-bit, odd 7-bit and 130-bit
// instances covering latency, back-pressure, back-to-back and reset abort.
module tb_kara_mult_iter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic        iv8 = 0, or8 = 1, ir8, ov8;
    logic [7:0]  a8 = 0, b8 = 0;
    logic [3:0]  t8 = 0, ot8;
    logic [15:0] p8;

    logic        iv7 = 0, or7 = 1, ir7, ov7;
    logic [6:0]  a7 = 0, b7 = 0;
    logic [3:0]  t7 = 0, ot7;
    logic [13:0] p7;

    logic         iv130 = 0, or130 = 1, ir130, ov130;
    logic [129:0] a130 = 0, b130 = 0;
    logic [3:0]   t130 = 0, ot130;
    logic [259:0] p130;

    kara_mult_iter #(.WIDTH(8), .MUL_STAGES(2), .TAG_W(4)) u8 (
        .clk(clk), .rst(rst),
        .in_valid(iv8), .in_ready(ir8),
        .in_a(a8), .in_b(b8), .in_tag(t8),
        .out_valid(ov8), .out_ready(or8),
        .out_p(p8), .out_tag(ot8)
    );

    kara_mult_iter #(.WIDTH(7), .MUL_STAGES(3), .TAG_W(4)) u7 (
        .clk(clk), .rst(rst),
        .in_valid(iv7), .in_ready(ir7),
        .in_a(a7), .in_b(b7), .in_tag(t7),
        .out_valid(ov7), .out_ready(or7),
        .out_p(p7), .out_tag(ot7)
    );

    kara_mult_iter #(.WIDTH(130), .MUL_STAGES(1), .TAG_W(4)) u130 (
        .clk(clk), .rst(rst),
        .in_valid(iv130), .in_ready(ir130),
        .in_a(a130), .in_b(b130), .in_tag(t130),
        .out_valid(ov130), .out_ready(or130),
        .out_p(p130), .out_tag(ot130)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] t);
        int n = 0;
        while (!ir8 && n < 50) begin cyc(); n++; end
        a8 = a; b8 = b; t8 = t; iv8 = 1;
        cyc();
        iv8 = 0;
    endtask

    task automatic wait8(output int lat);
        lat = 0;
        while (!ov8 && lat < 50) begin cyc(); lat++; end
        if (!ov8) lat = -1;
    endtask

    task automatic issue7(input logic [6:0] a, input logic [6:0] b,
                          input logic [3:0] t);
        int n = 0;
        while (!ir7 && n < 50) begin cyc(); n++; end
        a7 = a; b7 = b; t7 = t; iv7 = 1;
        cyc();
        iv7 = 0;
    endtask

    task automatic wait7(output int lat);
        lat = 0;
        while (!ov7 && lat < 50) begin cyc(); lat++; end
        if (!ov7) lat = -1;
    endtask

    task automatic issue130(input logic [129:0] a, input logic [129:0] b,
                            input logic [3:0] t);
        int n = 0;
        while (!ir130 && n < 50) begin cyc(); n++; end
        a130 = a; b130 = b; t130 = t; iv130 = 1;
        cyc();
        iv130 = 0;
    endtask

    task automatic wait130(output int lat);
        lat = 0;
        while (!ov130 && lat < 50) begin cyc(); lat++; end
        if (!ov130) lat = -1;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({ov8, ov7, ov130} !== 3'b000)
            $display("FAIL reset_valid got=%b exp=000", {ov8, ov7, ov130});
        else passed++;
        total++;
        if (p8 !== 16'd0 || ot8 !== 4'd0)
            $display("FAIL reset_out p=%0d tag=%0d exp=0/0", p8, ot8);
        else passed++;
        cyc();
        @(negedge clk);
        rst = 0;
        cyc();
        total++;
        if ({ir8, ir7, ir130} !== 3'b111)
            $display("FAIL reset_ready got=%b exp=111", {ir8, ir7, ir130});
        else passed++;
    endtask

    task automatic test_latency();
        int lat;
        or8 = 1;
        issue8(8'd255, 8'd255, 4'd5);
        wait8(lat);
        total++;
        if (lat !== 7) $display("FAIL lat8 got=%0d exp=7", lat);
        else passed++;
        total++;
        if (p8 !== 16'd65025) $display("FAIL prod8 got=%0d exp=65025", p8);
        else passed++;
        total++;
        if (ot8 !== 4'd5) $display("FAIL tag8 got=%0d exp=5", ot8);
        else passed++;
        cyc();
        total++;
        if (ov8 !== 1'b0) $display("FAIL hold1 got=%b exp=0", ov8);
        else passed++;
    endtask

    task automatic test_odd_width();
        int lat;
        logic [6:0]  av [3] = '{7'd127, 7'd0, 7'd1};
        logic [6:0]  bv [3] = '{7'd127, 7'd99, 7'd64};
        logic [13:0] ev [3] = '{14'd16129, 14'd0, 14'd64};
        or7 = 1;
        for (int i = 0; i < 3; i++) begin
            issue7(av[i], bv[i], 4'(i + 1));
            wait7(lat);
            total++;
            if (lat !== 8) $display("FAIL lat7_%0d got=%0d exp=8", i, lat);
            else passed++;
            total++;
            if (p7 !== ev[i] || ot7 !== 4'(i + 1))
                $display("FAIL prod7_%0d got=%0d/%0d exp=%0d/%0d",
                         i, p7, ot7, ev[i], i + 1);
            else passed++;
            cyc();
        end
    endtask

    task automatic test_wide();
        int lat;
        logic [129:0] ones = '1;
        logic [129:0] top  = '0;
        logic [259:0] e0, e2;
        top[129] = 1'b1;
        e0 = {{129{1'b1}}, 131'd1};
        e2 = '0;
        e2[258] = 1'b1;
        or130 = 1;
        issue130(ones, ones, 4'd6);
        wait130(lat);
        total++;
        if (lat !== 6) $display("FAIL lat130 got=%0d exp=6", lat);
        else passed++;
        total++;
        if (p130 !== e0 || ot130 !== 4'd6)
            $display("FAIL wide_ones got=%h exp=%h", p130, e0);
        else passed++;
        cyc();
        issue130(ones, 130'd1, 4'd7);
        wait130(lat);
        total++;
        if (p130 !== 260'(ones)) $display("FAIL wide_x1 got=%h exp=%h", p130, ones);
        else passed++;
        cyc();
        issue130(top, top, 4'd8);
        wait130(lat);
        total++;
        if (p130 !== e2) $display("FAIL wide_top got=%h exp=%h", p130, e2);
        else passed++;
        cyc();
    endtask

    task automatic test_back_to_back();
        int lat;
        or8 = 1;
        issue8(8'd12, 8'd34, 4'd1);
        wait8(lat);
        total++;
        if (p8 !== 16'd408 || ot8 !== 4'd1)
            $display("FAIL b2b_first got=%0d/%0d exp=408/1", p8, ot8);
        else passed++;
        issue8(8'd250, 8'd3, 4'd2);
        total++;
        if (ov8 !== 1'b0) $display("FAIL b2b_drop got=%b exp=0", ov8);
        else passed++;
        wait8(lat);
        total++;
        if (lat !== 7) $display("FAIL b2b_lat got=%0d exp=7", lat);
        else passed++;
        total++;
        if (p8 !== 16'd750 || ot8 !== 4'd2)
            $display("FAIL b2b_second got=%0d/%0d exp=750/2", p8, ot8);
        else passed++;
        cyc();
    endtask

    task automatic test_backpressure();
        int lat;
        or8 = 0;
        issue8(8'd100, 8'd200, 4'd9);
        wait8(lat);
        total++;
        if (lat !== 7) $display("FAIL bp_lat got=%0d exp=7", lat);
        else passed++;
        for (int i = 0; i < 10; i++) begin
            iv8 = i[0];
            a8 = 8'(i + 1);
            b8 = 8'(i + 2);
            t8 = 4'(i);
            #1;
            total++;
            if (ir8 !== 1'b0 || ov8 !== 1'b1 || p8 !== 16'd20000 || ot8 !== 4'd9)
                $display("FAIL bp_hold_%0d rdy=%b v=%b p=%0d t=%0d exp=0/1/20000/9",
                         i, ir8, ov8, p8, ot8);
            else passed++;
            cyc();
        end
        a8 = 8'd7; b8 = 8'd11; t8 = 4'd3; iv8 = 1; or8 = 1;
        #1;
        total++;
        if (ir8 !== 1'b1) $display("FAIL bp_release_rdy got=%b exp=1", ir8);
        else passed++;
        cyc();
        iv8 = 0;
        total++;
        if (ov8 !== 1'b0) $display("FAIL bp_drop got=%b exp=0", ov8);
        else passed++;
        wait8(lat);
        total++;
        if (lat !== 7 || p8 !== 16'd77 || ot8 !== 4'd3)
            $display("FAIL bp_next lat=%0d p=%0d t=%0d exp=7/77/3", lat, p8, ot8);
        else passed++;
        cyc();
    endtask

    task automatic test_reset_midop();
        int lat;
        or8 = 1;
        issue8(8'd200, 8'd100, 4'd7);
        cyc();
        #3;
        rst = 1;
        #1;
        total++;
        if (ov8 !== 1'b0 || ir8 !== 1'b1)
            $display("FAIL rst_mid v=%b rdy=%b exp=0/1", ov8, ir8);
        else passed++;
        cyc();
        cyc();
        @(negedge clk);
        rst = 0;
        cyc();
        total++;
        if (ir8 !== 1'b1 || ov8 !== 1'b0)
            $display("FAIL rst_release rdy=%b v=%b exp=1/0", ir8, ov8);
        else passed++;
        issue8(8'd3, 8'd5, 4'd4);
        wait8(lat);
        total++;
        if (lat !== 7 || p8 !== 16'd15 || ot8 !== 4'd4)
            $display("FAIL rst_next lat=%0d p=%0d t=%0d exp=7/15/4", lat, p8, ot8);
        else passed++;
        cyc();
    endtask

    task automatic test_random();
        int lat;
        logic [7:0] a, b;
        logic [3:0] t;
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            t = 4'($urandom_range(0, 15));
            or8 = 0;
            issue8(a, b, t);
            wait8(lat);
            repeat ($urandom_range(0, 3)) cyc();
            total++;
            if (lat !== 7 || p8 !== 16'(a) * 16'(b) || ot8 !== t)
                $display("FAIL rand_%0d lat=%0d p=%0d t=%0d exp=7/%0d/%0d",
                         i, lat, p8, ot8, 16'(a) * 16'(b), t);
            else passed++;
            or8 = 1;
            cyc();
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_odd_width();
        test_wide();
        test_back_to_back();
        test_backpressure();
        test_reset_midop();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
